bp_event_profiler_bank: RTL and testbench

Parametrised profiling counter bank that replaces fixed-slot, hand-instantiated counter lists with `els_p` generic event channels. It adds saturating or wrapping counters, sticky overflow flags, and periodic or on-demand snapshots streamed out through a valid/yumi handshake. It sits beside the core profiler in the cosim shell: stall-reason and metric strobes drive `event_i`, and the shell's CSR/AXI readout drains live and snapshot values.

---
 rtl/bp_event_profiler_bank.sv | 156 +++++++++++++++
 tb/tb_bp_event_profiler_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_event_profiler_bank.sv
//------------------------------------------------------------------------------
// Module   : bp_event_profiler_bank
// Function : Bank of per-channel event counters with sticky overflow flags and
//            periodic/manual snapshots drained through a valid/yumi handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_event_profiler_bank #(
    parameter int els_p            = 56,
    parameter int width_p          = 32,
    parameter int sat_p            = 1,
    parameter int clear_on_snap_p  = 0,
    parameter int interval_width_p = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          freeze_i,
    input  logic                          en_i,
    input  logic [els_p-1:0]              event_i,
    input  logic [interval_width_p-1:0]   interval_i,
    input  logic                          snap_i,
    input  logic                          snap_yumi_i,
    output logic [els_p*width_p-1:0]      data_o,
    output logic [els_p-1:0]              overflow_o,
    output logic [els_p*width_p-1:0]      snap_data_o,
    output logic                          snap_v_o,
    output logic [width_p-1:0]            epoch_o,
    output logic [width_p-1:0]            dropped_o
);

    localparam logic [0:0]                  c_st_empty = 1'b0;
    localparam logic [0:0]                  c_st_full  = 1'b1;
    localparam logic [interval_width_p-1:0] c_ivl_one  = interval_width_p'(1);
    localparam logic [width_p-1:0]          c_cnt_one  = width_p'(1);

    logic                        w_clear;
    logic                        w_ivl_on;
    logic                        w_auto;
    logic                        w_trig;
    logic                        w_load;
    logic                        w_drop;
    logic                        w_delta_clr;
    logic [0:0]                  r_state;
    logic [0:0]                  w_state_nxt;
    logic [interval_width_p-1:0] r_ivl;
    logic [width_p-1:0]          r_epoch;
    logic [width_p-1:0]          r_dropped;

    assign w_clear     = ~reset_n_i | freeze_i;
    assign w_ivl_on    = en_i & (interval_i != '0);
    assign w_auto      = w_ivl_on & (r_ivl == (interval_i - c_ivl_one));
    assign w_trig      = snap_i | w_auto;
    assign w_delta_clr = (clear_on_snap_p != 0) & w_trig;

    // Interval counter: a shrunken interval_i lets the counter run on until it wraps.
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_ivl <= '0;
        end else if (interval_i == '0) begin
            r_ivl <= '0;
        end else if (en_i) begin
            r_ivl <= w_auto ? '0 : r_ivl + c_ivl_one;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_chan
            logic               w_inc;
            logic               w_at_max;
            logic [width_p-1:0] w_next;
            logic [width_p-1:0] r_cnt;
            logic [width_p-1:0] r_snap;
            logic               r_ovf;

            assign w_inc    = en_i & event_i[gi];
            assign w_at_max = &r_cnt;
            assign w_next   = (w_inc & w_at_max & (sat_p != 0)) ? r_cnt
                            : (w_inc ? r_cnt + c_cnt_one : r_cnt);

            always_ff @(posedge clk_i) begin
                if (w_clear) begin
                    r_cnt  <= '0;
                    r_ovf  <= 1'b0;
                    r_snap <= '0;
                end else begin
                    r_cnt <= w_delta_clr ? '0 : w_next;
                    r_ovf <= r_ovf | (w_inc & w_at_max);
                    if (w_load) begin
                        r_snap <= w_next;
                    end
                end
            end

            assign data_o[gi*width_p +: width_p]      = r_cnt;
            assign snap_data_o[gi*width_p +: width_p] = r_snap;
            assign overflow_o[gi]                     = r_ovf;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_empty: if (w_trig) w_state_nxt = c_st_full;
            c_st_full:  if (snap_yumi_i & ~w_trig) w_state_nxt = c_st_empty;
            default:    w_state_nxt = c_st_empty;
        endcase
    end

    // A trigger while FULL is only accepted if the consumer drains in the same cycle.
    always_comb begin
        w_load = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            c_st_empty: w_load = w_trig;
            c_st_full: begin
                w_load = w_trig & snap_yumi_i;
                w_drop = w_trig & ~snap_yumi_i;
            end
            default: begin
                w_load = 1'b0;
                w_drop = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_epoch   <= '0;
            r_dropped <= '0;
        end else begin
            if (w_load) begin
                r_epoch <= r_epoch + c_cnt_one;
            end
            if (w_drop && !(&r_dropped)) begin
                r_dropped <= r_dropped + c_cnt_one;
            end
        end
    end

    assign snap_v_o  = (r_state == c_st_full);
    assign epoch_o   = r_epoch;
    assign dropped_o = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_bp_event_profiler_bank.sv
//------------------------------------------------------------------------------
// Module   : tb_bp_event_profiler_bank
// Function : Directed vector bench for bp_event_profiler_bank (three parameter sets).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bp_event_profiler_bank;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       freeze;
    logic       en;
    logic [3:0] ev;
    logic [7:0] ivl;
    logic       snap;
    logic       yumi;

    logic [31:0] c_data, c_snap;
    logic [3:0]  c_ovf;
    logic        c_v;
    logic [7:0]  c_epoch, c_drop;

    logic [15:0] w_data, w_snap;
    logic [3:0]  w_ovf;
    logic        w_v;
    logic [3:0]  w_epoch, w_drop;

    logic [15:0] d_data, d_snap;
    logic [3:0]  d_ovf;
    logic        d_v;
    logic [3:0]  d_epoch, d_drop;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bp_event_profiler_bank #(.els_p(4), .width_p(8), .sat_p(1), .clear_on_snap_p(0),
                             .interval_width_p(8)) u_cum (
        .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .en_i(en), .event_i(ev),
        .interval_i(ivl), .snap_i(snap), .snap_yumi_i(yumi), .data_o(c_data),
        .overflow_o(c_ovf), .snap_data_o(c_snap), .snap_v_o(c_v), .epoch_o(c_epoch),
        .dropped_o(c_drop));

    bp_event_profiler_bank #(.els_p(4), .width_p(4), .sat_p(0), .clear_on_snap_p(0),
                             .interval_width_p(8)) u_wrap (
        .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .en_i(en), .event_i(ev),
        .interval_i(ivl), .snap_i(snap), .snap_yumi_i(yumi), .data_o(w_data),
        .overflow_o(w_ovf), .snap_data_o(w_snap), .snap_v_o(w_v), .epoch_o(w_epoch),
        .dropped_o(w_drop));

    bp_event_profiler_bank #(.els_p(4), .width_p(4), .sat_p(1), .clear_on_snap_p(1),
                             .interval_width_p(8)) u_delta (
        .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .en_i(en), .event_i(ev),
        .interval_i(ivl), .snap_i(snap), .snap_yumi_i(yumi), .data_o(d_data),
        .overflow_o(d_ovf), .snap_data_o(d_snap), .snap_v_o(d_v), .epoch_o(d_epoch),
        .dropped_o(d_drop));

    typedef struct {
        int          n;
        logic        rst_n;
        logic        frz;
        logic        en;
        logic [3:0]  ev;
        logic [7:0]  ivl;
        logic        snap;
        logic        yumi;
        logic [31:0] e_data;
        logic [31:0] e_snap;
        logic [3:0]  e_ovf;
        logic        e_v;
        logic [7:0]  e_epoch;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic e, input logic [3:0] v,
                         input logic [7:0] iv, input logic s, input logic y);
        reset_n = r; freeze = f; en = e; ev = v; ivl = iv; snap = s; yumi = y;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // n rst frz en ev ivl snap yumi | data snap ovf v epoch dropped
        tbl[0] = '{2,  1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0, 8'd0, 8'd0};
        tbl[1] = '{10, 1'b1, 1'b0, 1'b1, 4'h5, 8'd0, 1'b0, 1'b0, 32'h000A_000A, 32'h0, 4'h0, 1'b0, 8'd0, 8'd0};
        tbl[2] = '{5,  1'b1, 1'b0, 1'b0, 4'h5, 8'd0, 1'b0, 1'b0, 32'h000A_000A, 32'h0, 4'h0, 1'b0, 8'd0, 8'd0};
        tbl[3] = '{1,  1'b1, 1'b0, 1'b0, 4'h5, 8'd0, 1'b1, 1'b0, 32'h000A_000A, 32'h000A_000A, 4'h0, 1'b1, 8'd1, 8'd0};
        tbl[4] = '{2,  1'b1, 1'b0, 1'b1, 4'h1, 8'd0, 1'b0, 1'b0, 32'h000A_000C, 32'h000A_000A, 4'h0, 1'b1, 8'd1, 8'd0};
        tbl[5] = '{1,  1'b1, 1'b0, 1'b1, 4'h1, 8'd0, 1'b1, 1'b0, 32'h000A_000D, 32'h000A_000A, 4'h0, 1'b1, 8'd1, 8'd1};
        tbl[6] = '{1,  1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1, 32'h000A_000D, 32'h000A_000A, 4'h0, 1'b0, 8'd1, 8'd1};
        tbl[7] = '{1,  1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b1, 32'h000A_000D, 32'h000A_000A, 4'h0, 1'b0, 8'd1, 8'd1};

        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].rst_n, tbl[i].frz, tbl[i].en, tbl[i].ev, tbl[i].ivl, tbl[i].snap, tbl[i].yumi);
            for (int k = 0; k < tbl[i].n; k++) tick();
            chk($sformatf("tbl%0d_data", i),    64'(c_data),  64'(tbl[i].e_data));
            chk($sformatf("tbl%0d_snap", i),    64'(c_snap),  64'(tbl[i].e_snap));
            chk($sformatf("tbl%0d_ovf", i),     64'(c_ovf),   64'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_v", i),       64'(c_v),     64'(tbl[i].e_v));
            chk($sformatf("tbl%0d_epoch", i),   64'(c_epoch), 64'(tbl[i].e_epoch));
            chk($sformatf("tbl%0d_dropped", i), 64'(c_drop),  64'(tbl[i].e_drop));
        end

        // Saturate vs wrap on a 4-bit channel 0, no triggers.
        drive(1'b1, 1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 4'h1, 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) tick();
        chk("wrap_15_data", 64'(w_data), 64'h000F);
        chk("wrap_15_ovf",  64'(w_ovf),  64'h0);
        chk("sat_15_ovf",   64'(d_ovf),  64'h0);
        tick();
        chk("wrap_16_data", 64'(w_data), 64'h0000);
        chk("wrap_16_ovf",  64'(w_ovf),  64'h1);
        chk("sat_16_data",  64'(d_data), 64'h000F);
        chk("sat_16_ovf",   64'(d_ovf),  64'h1);
        for (int k = 0; k < 4; k++) tick();
        chk("wrap_20_data", 64'(w_data), 64'h0004);
        chk("sat_20_data",  64'(d_data), 64'h000F);
        chk("sat_20_ovf",   64'(d_ovf),  64'h1);
        chk("cum_20_data",  64'(c_data), 64'h0000_0014);

        // Auto snapshot every 8 cycles, delta mode, consumer drains immediately.
        drive(1'b1, 1'b1, 1'b0, 4'h0, 8'd8, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 4'h1, 8'd8, 1'b0, 1'b0);
        for (int t = 1; t <= 24; t++) begin
            yumi = d_v;
            tick();
            chk($sformatf("delta_v_t%0d", t), 64'(d_v), 64'((t % 8) == 0));
            chk($sformatf("delta_data_t%0d", t), 64'(d_data), 64'(t % 8));
            if ((t % 8) == 0) chk($sformatf("delta_snap_t%0d", t), 64'(d_snap), 64'h0008);
        end
        chk("delta_epoch_24", 64'(d_epoch), 64'd3);
        chk("delta_drop_24",  64'(d_drop),  64'd0);

        // Backpressure: interval 4, no yumi for 12 cycles.
        drive(1'b1, 1'b1, 1'b0, 4'h0, 8'd4, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 4'h1, 8'd4, 1'b0, 1'b0);
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 4) begin
                chk("bp_t4_v",     64'(c_v),     64'd1);
                chk("bp_t4_epoch", 64'(c_epoch), 64'd1);
                chk("bp_t4_snap",  64'(c_snap),  64'h0000_0004);
            end
        end
        chk("bp_t12_v",       64'(c_v),     64'd1);
        chk("bp_t12_snap",    64'(c_snap),  64'h0000_0004);
        chk("bp_t12_dropped", 64'(c_drop),  64'd2);
        chk("bp_t12_epoch",   64'(c_epoch), 64'd1);
        chk("bp_t12_data",    64'(c_data),  64'h0000_000C);
        chk("bp_t12_ddata",   64'(d_data),  64'h0000);
        chk("bp_t12_ddrop",   64'(d_drop),  64'd2);
        for (int t = 13; t <= 15; t++) tick();
        yumi = 1'b1;
        tick();
        chk("bp_t16_v",       64'(c_v),     64'd1);
        chk("bp_t16_epoch",   64'(c_epoch), 64'd2);
        chk("bp_t16_snap",    64'(c_snap),  64'h0000_0010);
        chk("bp_t16_dropped", 64'(c_drop),  64'd2);
        tick();
        chk("bp_t17_v", 64'(c_v), 64'd0);

        // Manual snap coinciding with an auto trigger counts once.
        yumi = 1'b0;
        tick();
        tick();
        snap = 1'b1;
        tick();
        chk("sim_t20_v",       64'(c_v),     64'd1);
        chk("sim_t20_epoch",   64'(c_epoch), 64'd3);
        chk("sim_t20_snap",    64'(c_snap),  64'h0000_0014);
        chk("sim_t20_dropped", 64'(c_drop),  64'd2);
        chk("sim_t20_wovf",    64'(w_ovf),   64'h1);
        chk("sim_t20_wdata",   64'(w_data),  64'h0004);

        // Freeze while FULL with overflow set and every event strobing.
        drive(1'b1, 1'b1, 1'b1, 4'hF, 8'd4, 1'b1, 1'b0);
        tick();
        chk("frz_data",    64'(c_data),  64'h0);
        chk("frz_ovf",     64'(c_ovf),   64'h0);
        chk("frz_snap",    64'(c_snap),  64'h0);
        chk("frz_v",       64'(c_v),     64'h0);
        chk("frz_epoch",   64'(c_epoch), 64'h0);
        chk("frz_dropped", 64'(c_drop),  64'h0);
        chk("frz_wovf",    64'(w_ovf),   64'h0);
        chk("frz_wdata",   64'(w_data),  64'h0);
        drive(1'b1, 1'b0, 1'b1, 4'hF, 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        chk("resume_data",  64'(c_data),  64'h0303_0303);
        chk("resume_v",     64'(c_v),     64'd0);
        chk("resume_epoch", 64'(c_epoch), 64'd0);
        reset_n = 1'b0;
        tick();
        chk("rst_data", 64'(c_data), 64'h0);
        reset_n = 1'b1;
        tick();
        chk("rst_release_data", 64'(c_data), 64'h0101_0101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
